// File: rtl/ofmap_readout_pkg.sv
// Shared widths, FSM state encoding and host-facing word type for the ofmap read-back path.
package ofmap_readout_pkg;

  localparam int unsigned OFM_DATA_WIDTH = 8;
  localparam int unsigned OFM_ADDR_WIDTH = 14;
  localparam int unsigned OFM_PACK       = 4;
  localparam int unsigned OFM_WORD_WIDTH = OFM_PACK * OFM_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } ofm_state_t;

  typedef struct packed {
    logic [OFM_WORD_WIDTH-1:0] data;
    logic [OFM_PACK-1:0]       keep;
    logic                      last;
  } ofm_word_t;

endpackage

// File: rtl/ofmap_readout_byte_packer.sv
// Lane-steering pack register feeding a single valid/ready output slot.
// A word completed by the arriving byte bypasses the pack register when the slot is free.
module ofmap_readout_byte_packer
  import ofmap_readout_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = OFM_DATA_WIDTH,
  parameter int unsigned PACK       = OFM_PACK
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rden,
  input  logic                       rd_last,
  input  logic [DATA_WIDTH-1:0]      rdata,
  output logic [$clog2(PACK+1)-1:0]  fill_next_c,
  output logic                       last_fire_c,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [PACK*DATA_WIDTH-1:0] m_data,
  output logic [PACK-1:0]            m_keep,
  output logic                       m_last
);

  localparam int unsigned CNT_W  = $clog2(PACK + 1);
  localparam int unsigned WORD_W = PACK * DATA_WIDTH;

  logic              inflight_q;
  logic              inflight_last_q;
  logic [WORD_W-1:0] pack_q;
  logic [WORD_W-1:0] pack_n;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_n;
  logic              pack_last_q;
  logic              pack_last_n;

  logic              out_valid_q;
  logic [WORD_W-1:0] out_data_q;
  logic [PACK-1:0]   out_keep_q;
  logic              out_last_q;

  logic              out_free;
  logic              word_ready;
  logic              merged_done;
  logic              load;
  logic [WORD_W-1:0] merged_data;
  logic [WORD_W-1:0] load_data;
  logic [CNT_W-1:0]  merged_cnt;
  logic [CNT_W-1:0]  load_cnt;
  logic              load_last;

  // Merge the arriving byte into its lane and decide whether a word moves to the output slot.
  always_comb begin
    out_free    = !out_valid_q || m_ready;
    word_ready  = (cnt_q == CNT_W'(PACK)) || pack_last_q;
    merged_data = pack_q | (WORD_W'(rdata) << (32'(cnt_q) * DATA_WIDTH));
    merged_cnt  = cnt_q + CNT_W'(1);
    merged_done = (merged_cnt == CNT_W'(PACK)) || inflight_last_q;

    pack_n      = pack_q;
    cnt_n       = cnt_q;
    pack_last_n = pack_last_q;
    load        = 1'b0;
    load_data   = pack_q;
    load_cnt    = cnt_q;
    load_last   = pack_last_q;

    if (word_ready) begin
      if (out_free) begin
        load        = 1'b1;
        pack_n      = '0;
        cnt_n       = '0;
        pack_last_n = 1'b0;
      end
    end else if (inflight_q) begin
      if (merged_done && out_free) begin
        load        = 1'b1;
        load_data   = merged_data;
        load_cnt    = merged_cnt;
        load_last   = inflight_last_q;
        pack_n      = '0;
        cnt_n       = '0;
        pack_last_n = 1'b0;
      end else begin
        pack_n      = merged_data;
        cnt_n       = merged_cnt;
        pack_last_n = inflight_last_q;
      end
    end
  end

  assign fill_next_c = cnt_n;
  assign last_fire_c = out_valid_q && m_ready && out_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      pack_q          <= '0;
      cnt_q           <= '0;
      pack_last_q     <= 1'b0;
    end else begin
      inflight_q      <= rden;
      inflight_last_q <= rden && rd_last;
      pack_q          <= pack_n;
      cnt_q           <= cnt_n;
      pack_last_q     <= pack_last_n;
    end
  end

  // Output slot: holds its word until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= load_data;
      out_keep_q  <= PACK'((32'd1 << load_cnt) - 32'd1);
      out_last_q  <= load_last;
    end else if (out_valid_q && m_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;
  assign m_keep  = out_keep_q;
  assign m_last  = out_last_q;

endmodule

// File: rtl/ofmap_readout.sv
// Walks the result buffer through its byte read port and streams the bytes out packed into words.
// Read enable and address are registered from next-cycle state so the issue rule sees post-edge fill.
module ofmap_readout
  import ofmap_readout_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = OFM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = OFM_ADDR_WIDTH,
  parameter int unsigned PACK       = OFM_PACK
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [ADDR_WIDTH-1:0]      base_addr_i,
  input  logic [ADDR_WIDTH-1:0]      len_i,
  output logic                       rden_o,
  output logic [ADDR_WIDTH-1:0]      rdptr_o,
  input  logic [DATA_WIDTH-1:0]      rdata_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [PACK*DATA_WIDTH-1:0] m_data_o,
  output logic [PACK-1:0]            m_keep_o,
  output logic                       m_last_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int unsigned CNT_W = $clog2(PACK + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  ofm_state_t state_q;
  ofm_state_t state_n;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] base_n;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] len_n;
  logic [ADDR_WIDTH-1:0] issued_q;
  logic [ADDR_WIDTH-1:0] issued_n;
  logic [ADDR_WIDTH-1:0] rdptr_q;
  logic [ADDR_WIDTH-1:0] rdptr_n;
  logic                  rden_q;
  logic                  rden_n;
  logic                  rd_last_q;
  logic                  rd_last_n;
  logic                  busy_q;
  logic                  busy_n;
  logic                  done_q;
  logic                  done_n;

  logic [CNT_W-1:0]      fill_next;
  logic                  last_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // DONE is held until the registered pulse is out, which also gives len==0 its extra cycle.
  always_comb begin
    state_n  = state_q;
    base_n   = base_q;
    len_n    = len_q;
    issued_n = issued_q + ADDR_WIDTH'(rden_q);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_n   = base_addr_i;
          len_n    = len_i;
          issued_n = '0;
          state_n  = (len_i == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issued_n == len_q) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (last_fire) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (done_q) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    rden_n    = (state_n == READ) && (issued_n < len_n) &&
                ((SUM_W'(fill_next) + SUM_W'(rden_q)) < SUM_W'(PACK));
    rd_last_n = rden_n && ((issued_n + ADDR_WIDTH'(1)) == len_n);
    rdptr_n   = rden_n ? (base_n + issued_n) : rdptr_q;
    done_n    = (state_n == DONE) && (state_q != IDLE);
    busy_n    = (state_n != IDLE) && !done_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q    <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      rdptr_q   <= '0;
      rden_q    <= 1'b0;
      rd_last_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      base_q    <= base_n;
      len_q     <= len_n;
      issued_q  <= issued_n;
      rdptr_q   <= rdptr_n;
      rden_q    <= rden_n;
      rd_last_q <= rd_last_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
    end
  end

  assign rden_o  = rden_q;
  assign rdptr_o = rdptr_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

  ofmap_readout_byte_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .PACK       (PACK)
  ) u_byte_packer (
    .clk         (clk),
    .rst         (rst),
    .rden        (rden_q),
    .rd_last     (rd_last_q),
    .rdata       (rdata_i),
    .fill_next_c (fill_next),
    .last_fire_c (last_fire),
    .m_valid     (m_valid_o),
    .m_ready     (m_ready_i),
    .m_data      (m_data_o),
    .m_keep      (m_keep_o),
    .m_last      (m_last_o)
  );

endmodule

// File: tb/tb_ofmap_readout.sv
// Bench for ofmap_readout: buffer model, word-level scoreboard built from the byte stream, timing pins.
module tb_ofmap_readout;
  import ofmap_readout_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [13:0] base_i = '0;
  logic [13:0] len_i = '0;
  logic        rden_o;
  logic [13:0] rdptr_o;
  logic [7:0]  rdata_i = '0;
  logic        m_valid_o;
  logic        m_ready_i = 1'b1;
  logic [31:0] m_data_o;
  logic [3:0]  m_keep_o;
  logic        m_last_o;
  logic        busy_o;
  logic        done_o;

  ofmap_readout dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_i),
    .len_i       (len_i),
    .rden_o      (rden_o),
    .rdptr_o     (rdptr_o),
    .rdata_i     (rdata_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_keep_o    (m_keep_o),
    .m_last_o    (m_last_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 0;
  logic [7:0] salt = '0;

  logic        check_en = 1'b0;
  logic        active = 1'b0;
  logic        busy_exp = 1'b0;
  logic        stall_prev = 1'b0;
  int          start_cyc = -100;
  int          start_len = 0;
  int          exp_done_cyc = -100;
  int          done_cyc = -100;
  int          first_valid_cyc = -1;
  int          rden_cnt = 0;
  int          done_cnt = 0;

  logic [13:0] addr_q[$];
  ofm_word_t   word_q[$];
  ofm_word_t   got_q[$];
  ofm_word_t   cur;
  ofm_word_t   prev_word;
  ofm_word_t   ew;

  logic        mem_pend;
  logic [13:0] mem_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [13:0] a);
    return a[7:0] ^ salt;
  endfunction

  // Expected read addresses and words straight from the byte index rules.
  task automatic load_model(input logic [13:0] b, input logic [13:0] l);
    ofm_word_t w;
    logic [13:0] a;
    w = '0;
    for (int k = 0; k < int'(l); k++) begin
      a = b + 14'(k);
      addr_q.push_back(a);
      w.data[8*(k%4) +: 8] = byte_at(a);
      w.keep[k%4] = 1'b1;
      if ((k % 4) == 3 || k == int'(l) - 1) begin
        w.last = (k == int'(l) - 1);
        word_q.push_back(w);
        w = '0;
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Result buffer: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    mem_pend = rden_o;
    mem_addr = rdptr_o;
    #1;
    rdata_i = mem_pend ? byte_at(mem_addr) : 8'($urandom);
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready_i = 1'b1;
      1:       m_ready_i = (cyc % 3 == 0);
      default: m_ready_i = 1'($urandom);
    endcase
  end

  always @(negedge clk) begin
    if (check_en) begin
      if (active && cyc == start_cyc + 1) begin
        busy_exp = 1'b1;
        check("start_rden", 64'(rden_o), 64'(start_len != 0));
      end
      if (cyc == exp_done_cyc) busy_exp = 1'b0;
      check("busy", 64'(busy_o), 64'(busy_exp));
      if (done_o || cyc == exp_done_cyc)
        check("done_cycle", 64'(done_o), 64'(cyc == exp_done_cyc));
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        active = 1'b0;
      end
      if (rden_o) begin
        rden_cnt++;
        if (addr_q.size() == 0) check("rden_extra", 64'(1), 64'(0));
        else check("rdptr", 64'(rdptr_o), 64'(addr_q.pop_front()));
      end
      cur = {m_data_o, m_keep_o, m_last_o};
      if (stall_prev) begin
        check("valid_hold", 64'(m_valid_o), 64'(1));
        check("data_stable", 64'(cur), 64'(prev_word));
      end
      if (m_valid_o) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_ready_i) begin
          if (word_q.size() == 0) begin
            check("word_extra", 64'(1), 64'(0));
          end else begin
            ew = word_q.pop_front();
            check("m_data", 64'(m_data_o), 64'(ew.data));
            check("m_keep", 64'(m_keep_o), 64'(ew.keep));
            check("m_last", 64'(m_last_o), 64'(ew.last));
            got_q.push_back(cur);
            if (ew.last) exp_done_cyc = cyc + 1;
          end
        end
      end
      stall_prev = m_valid_o && !m_ready_i;
      prev_word = cur;
    end
  end

  task automatic start_xfer(input logic [13:0] b, input logic [13:0] l, input logic [7:0] s);
    @(posedge clk);
    #1;
    salt = s;
    addr_q.delete();
    word_q.delete();
    got_q.delete();
    rden_cnt = 0;
    done_cnt = 0;
    first_valid_cyc = -1;
    load_model(b, l);
    start_i = 1'b1;
    base_i = b;
    len_i = l;
    start_cyc = cyc;
    start_len = int'(l);
    active = 1'b1;
    if (l == '0) exp_done_cyc = cyc + 2;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    base_i = 14'($urandom);
    len_i = 14'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("completion", 64'(done_cnt != 0), 64'(1));
    @(posedge clk);
    check("done_once", 64'(done_cnt), 64'(1));
    check("words_left", 64'(word_q.size()), 64'(0));
    check("reads_left", 64'(addr_q.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rden"}, 64'(rden_o), 64'(0));
    check({tag, "_rdptr"}, 64'(rdptr_o), 64'(0));
    check({tag, "_valid"}, 64'(m_valid_o), 64'(0));
    check({tag, "_data"}, 64'(m_data_o), 64'(0));
    check({tag, "_keep"}, 64'(m_keep_o), 64'(0));
    check({tag, "_last"}, 64'(m_last_o), 64'(0));
    check({tag, "_busy"}, 64'(busy_o), 64'(0));
    check({tag, "_done"}, 64'(done_o), 64'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    check_en = 1'b1;

    // Aligned transfer, byte = address LSB
    ready_mode = 0;
    start_xfer(14'h0100, 14'd8, 8'h00);
    wait_done(200);
    check("t1_words", 64'(got_q.size()), 64'(2));
    check("t1_w0", 64'(got_q[0].data), 64'h03020100);
    check("t1_w0_last", 64'(got_q[0].last), 64'(0));
    check("t1_w1", 64'(got_q[1].data), 64'h07060504);
    check("t1_w1_keep", 64'(got_q[1].keep), 64'hF);
    check("t1_w1_last", 64'(got_q[1].last), 64'(1));
    check("t1_first_valid", 64'(first_valid_cyc), 64'(start_cyc + 6));
    check("t1_done_cyc", 64'(done_cyc), 64'(start_cyc + 12));
    check("t1_rdens", 64'(rden_cnt), 64'(8));

    // Partial tail
    start_xfer(14'h0100, 14'd6, 8'h00);
    wait_done(200);
    check("t2_w1", 64'(got_q[1].data), 64'h00000504);
    check("t2_w1_keep", 64'(got_q[1].keep), 64'h3);
    check("t2_w1_last", 64'(got_q[1].last), 64'(1));

    // Address wrap
    start_xfer(14'h3FFE, 14'd4, 8'h00);
    wait_done(200);
    check("t3_words", 64'(got_q.size()), 64'(1));
    check("t3_w0", 64'(got_q[0].data), 64'h0100FFFE);
    check("t3_w0_keep", 64'(got_q[0].keep), 64'hF);

    // Backpressure, ready one cycle in three
    ready_mode = 1;
    start_xfer(14'h0100, 14'd16, 8'h00);
    wait_done(500);
    check("t4_words", 64'(got_q.size()), 64'(4));
    check("t4_w3", 64'(got_q[3].data), 64'h0F0E0D0C);
    check("t4_rdens", 64'(rden_cnt), 64'(16));
    ready_mode = 0;

    // Zero length
    start_xfer(14'h0123, 14'd0, 8'h00);
    wait_done(50);
    check("t5_done_cyc", 64'(done_cyc), 64'(start_cyc + 2));
    check("t5_rdens", 64'(rden_cnt), 64'(0));
    check("t5_no_valid", 64'(first_valid_cyc), 64'(-1));

    // Start while busy is ignored
    start_xfer(14'h0200, 14'd8, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    start_i = 1'b1;
    base_i = 14'h0000;
    len_i = 14'd3;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(200);
    check("t6_words", 64'(got_q.size()), 64'(2));
    check("t6_w1", 64'(got_q[1].data), 64'h07060504);
    check("t6_rdens", 64'(rden_cnt), 64'(8));

    // Reset after three reads
    start_xfer(14'h0300, 14'd16, 8'h00);
    n = 0;
    while (rden_cnt < 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("t7_three_reads", 64'(rden_cnt >= 3), 64'(1));
    #1;
    check_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    addr_q.delete();
    word_q.delete();
    active = 1'b0;
    busy_exp = 1'b0;
    stall_prev = 1'b0;
    exp_done_cyc = -100;
    done_cnt = 0;
    check_en = 1'b1;
    repeat (10) @(posedge clk);
    check("t7_no_done", 64'(done_cnt), 64'(0));
    start_xfer(14'h0300, 14'd16, 8'h5A);
    wait_done(300);
    check("t7_words", 64'(got_q.size()), 64'(4));
    check("t7_rdens", 64'(rden_cnt), 64'(16));

    // Randomized transfers
    for (int t = 0; t < 20; t++) begin
      ready_mode = int'($urandom_range(0, 2));
      start_xfer(14'($urandom), 14'($urandom_range(1, 40)), 8'($urandom));
      wait_done(2000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end

endmodule
